// File: rtl/mmio_io_pkg.sv
// Shared constants and types for the memory-mapped display/LED output block.
package mmio_io_pkg;

    // Default store addresses decoded by the controller
    localparam logic [31:0] DEF_DISP_ADDR = 32'h0000_FF00;
    localparam logic [31:0] DEF_LED_ADDR  = 32'h0000_FF04;
    localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_FF08;

    // 1 s per half at 25 MHz
    localparam int unsigned DEF_HOLD_CYCLES = 25_000_000;

    // Control register mode field (bits [1:0])
    typedef enum logic [1:0] {
        MODE_LO    = 2'b00,
        MODE_HI    = 2'b01,
        MODE_AUTO  = 2'b10,
        MODE_BLANK = 2'b11
    } disp_mode_t;

    // Which view the seven-segment subsystem is showing
    typedef enum logic [1:0] {
        SHOW_LO = 2'b00,
        SHOW_HI = 2'b01,
        BLANK   = 2'b10
    } disp_state_t;

endpackage

// File: rtl/page_hold_timer.sv
// Dwell timer for auto page alternation: counts while run is high and pulses
// expire during the last cycle of each HOLD_CYCLES-long period.
module page_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expire
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: cleared on restart or when idle, wraps after the last cycle
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        expire = 1'b0;
        if (restart || !run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            expire = 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_display_controller.sv
// Memory-mapped output controller: decodes processor stores into the display
// word, LED word and mode register, and schedules which display half is shown.
module mmio_display_controller
    import mmio_io_pkg::*;
#(
    parameter logic [31:0] DISP_ADDR   = DEF_DISP_ADDR,
    parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR,
    parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic [15:0] disp_value,
    output logic        disp_blank,
    output logic        disp_page,
    output logic [15:0] led_value
);

    logic        hit_disp, hit_led, hit_ctrl;
    logic [31:0] disp_word_q, disp_word_d;
    logic [15:0] led_q, led_d;
    disp_mode_t  mode_q, mode_d;
    disp_state_t state_q, state_d;
    logic        expire;

    logic        wr_ack_q;
    logic [15:0] disp_value_q, disp_value_d;
    logic        disp_blank_q, disp_blank_d;
    logic        disp_page_q, disp_page_d;

    // Full-width address decode; each strobed cycle is an independent store
    always_comb begin
        hit_disp = wr_en && (wr_addr == DISP_ADDR);
        hit_led  = wr_en && (wr_addr == LED_ADDR);
        hit_ctrl = wr_en && (wr_addr == CTRL_ADDR);
    end

    // A CTRL write restarts the dwell period even when rewriting the same mode
    page_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_page_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (mode_q == MODE_AUTO),
        .restart (hit_ctrl),
        .expire  (expire)
    );

    // Register-file next state
    always_comb begin
        disp_word_d = disp_word_q;
        led_d       = led_q;
        mode_d      = mode_q;
        if (hit_disp) disp_word_d = wr_data;
        if (hit_led)  led_d       = wr_data[15:0];
        if (hit_ctrl) mode_d      = disp_mode_t'(wr_data[1:0]);
    end

    // FSM next state: a CTRL write overrides a coincident expiry
    always_comb begin
        state_d = state_q;
        if (hit_ctrl) begin
            unique case (mode_d)
                MODE_LO:    state_d = SHOW_LO;
                MODE_HI:    state_d = SHOW_HI;
                MODE_AUTO:  state_d = SHOW_LO;
                MODE_BLANK: state_d = BLANK;
                default:    state_d = SHOW_LO;
            endcase
        end else if (expire) begin
            state_d = (state_q == SHOW_HI) ? SHOW_LO : SHOW_HI;
        end
    end

    // Output next values from next state so new data appears one cycle after the store
    always_comb begin
        disp_value_d = '0;
        disp_blank_d = 1'b0;
        disp_page_d  = 1'b0;
        case (state_d)
            SHOW_LO: disp_value_d = disp_word_d[15:0];
            SHOW_HI: begin
                disp_value_d = disp_word_d[31:16];
                disp_page_d  = 1'b1;
            end
            BLANK:   disp_blank_d = 1'b1;
            default: disp_value_d = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_word_q  <= '0;
            led_q        <= '0;
            mode_q       <= MODE_LO;
            state_q      <= SHOW_LO;
            wr_ack_q     <= 1'b0;
            disp_value_q <= '0;
            disp_blank_q <= 1'b0;
            disp_page_q  <= 1'b0;
        end else begin
            disp_word_q  <= disp_word_d;
            led_q        <= led_d;
            mode_q       <= mode_d;
            state_q      <= state_d;
            wr_ack_q     <= hit_disp || hit_led || hit_ctrl;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
            disp_page_q  <= disp_page_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign disp_value = disp_value_q;
    assign disp_blank = disp_blank_q;
    assign disp_page  = disp_page_q;
    assign led_value  = led_q;

endmodule

// File: tb/tb_mmio_display_controller.sv
// Scoreboard bench for mmio_display_controller with a short auto-page period.
module tb_mmio_display_controller;

    localparam int unsigned HOLD = 4;
    localparam logic [31:0] A_DISP = 32'h0000_FF00;
    localparam logic [31:0] A_LED  = 32'h0000_FF04;
    localparam logic [31:0] A_CTRL = 32'h0000_FF08;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [15:0] disp_value;
    logic        disp_blank;
    logic        disp_page;
    logic [15:0] led_value;

    mmio_display_controller #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .disp_page  (disp_page),
        .led_value  (led_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [15:0] val;
        logic        blank;
        logic        page;
        logic [15:0] led;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: registers plus cycles elapsed since AUTO began
    logic [31:0] m_word;
    logic [15:0] m_led;
    logic [1:0]  m_mode;
    int          m_elapsed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: predicts the outputs visible after each edge (or reset)
    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            m_word = 0; m_led = 0; m_mode = 0; m_elapsed = 0;
            e.ack = 0; e.val = 0; e.blank = 0; e.page = 0; e.led = 0;
            q.delete();
            q.push_back(e);
        end else begin
            e.ack = wr_en && (wr_addr == A_DISP || wr_addr == A_LED || wr_addr == A_CTRL);
            if (wr_en && wr_addr == A_DISP) m_word = wr_data;
            if (wr_en && wr_addr == A_LED)  m_led  = wr_data[15:0];
            if (wr_en && wr_addr == A_CTRL) begin
                m_mode    = wr_data[1:0];
                m_elapsed = 0;
            end else if (m_mode == 2'd2) begin
                m_elapsed++;
            end
            e.blank = 0; e.page = 0; e.val = 0;
            case (m_mode)
                2'd0: e.val = m_word[15:0];
                2'd1: begin e.val = m_word[31:16]; e.page = 1; end
                2'd2: begin
                    e.page = ((m_elapsed / HOLD) % 2) == 1;
                    e.val  = e.page ? m_word[31:16] : m_word[15:0];
                end
                default: e.blank = 1;
            endcase
            e.led = m_led;
            q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the oldest prediction mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 1) begin
            total++;
            bad++;
            $display("FAIL scoreboard_depth: got %0d entries expected at most 1", q.size());
            q.delete();
        end else if (q.size() == 1) begin
            e = q.pop_front();
            chk("wr_ack", {31'b0, wr_ack}, {31'b0, e.ack});
            chk("disp_value", {16'b0, disp_value}, {16'b0, e.val});
            chk("disp_blank", {31'b0, disp_blank}, {31'b0, e.blank});
            chk("disp_page", {31'b0, disp_page}, {31'b0, e.page});
            chk("led_value", {16'b0, led_value}, {16'b0, e.led});
        end
    end

    // Called #1 after an edge; holds the store for exactly one sampling edge
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_addr = $urandom; wr_data = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Display word, fixed pages, blank
        store(A_DISP, 32'h1234_ABCD); idle(1);
        store(A_CTRL, 32'h0000_0001); idle(1);
        store(A_CTRL, 32'h0000_0003); idle(1);

        // Auto alternation over two full periods
        store(A_CTRL, 32'h0000_0002); idle(17);

        // LED store followed by unmapped store
        store(A_LED, 32'hBEEF_5A5A); store(32'h0000_FF10, 32'h1); idle(2);

        // CTRL write landing on the expiry cycle
        store(A_CTRL, 32'h0000_0002); idle(3);
        store(A_CTRL, 32'h0000_0000); idle(6);

        // Rewriting AUTO while on the high page restarts on the low page
        store(A_CTRL, 32'h0000_0002); idle(5);
        store(A_CTRL, 32'hFFFF_FFFE); idle(6);

        // Display write in AUTO keeps the page timing
        store(A_CTRL, 32'h0000_0002); idle(5);
        store(A_DISP, 32'hCAFE_F00D); idle(6);

        // Reset while on the high page with a store pending
        store(A_CTRL, 32'h0000_0002); idle(5);
        reset = 1'b1; wr_en = 1'b1; wr_addr = A_DISP; wr_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        reset = 1'b0; wr_en = 1'b0;
        idle(3);

        // Randomized traffic, CTRL stores kept rare so auto periods elapse
        for (int i = 0; i < 600; i++) begin
            int unsigned sel;
            wr_en   = ($urandom_range(0, 2) != 0);
            sel     = $urandom_range(0, 15);
            wr_data = $urandom;
            if (sel < 5)       wr_addr = A_DISP;
            else if (sel < 9)  wr_addr = A_LED;
            else if (sel < 10) wr_addr = A_CTRL;
            else if (sel < 12) wr_addr = A_DISP + 32'd12;
            else if (sel < 13) wr_addr = A_CTRL | 32'h0001_0000;
            else               wr_addr = $urandom;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
